// File: rtl/ah_packet_converter_w2n.sv
// Wide-to-narrow converter: buffers wide words and emits LANES narrow lanes each, LSB lane first unless AH_PKTCONV_W2N_MSB_FIRST_EN.
// Latency: write in cycle N -> first rvalid_o in N+2. Backpressure: credits in both directions (wcredit_o per popped word, rcredit_i per lane).

module ah_pktconv_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 2
) (
   input  logic         clk_i,
   input  logic         rstn_i,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] dat_i,
   output logic [W-1:0] dat_o,
   output logic         empty_o
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          full, do_push, do_pop;

   assign full    = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   // A push into a full FIFO is a protocol violation and is dropped.
   assign do_push = push_i && !full;
   assign do_pop  = pop_i && !empty_o;
   assign dat_o   = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= dat_i;
   end
endmodule

module ah_packet_converter_w2n #(
   parameter int WIDE_W   = 15,
   parameter int NARROW_W = 5,
   parameter int DEPTH    = 2,
   parameter int CRED_W   = 4
) (
   input  logic                clk_i,
   input  logic                rstn_i,
   input  logic [WIDE_W-1:0]   wdata_i,
   input  logic                wvalid_i,
   output logic                wcredit_o,
   output logic [NARROW_W-1:0] rdata_o,
   output logic                rvalid_o,
   input  logic                rcredit_i
);
   localparam int LANES = WIDE_W / NARROW_W;
   localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;

   logic [WIDE_W-1:0]   head;
   logic                empty, beat, last, pop;
   logic [NARROW_W-1:0] slice [LANES];
   logic [LW-1:0]       sel;
   logic [LW-1:0]       lane_q, lane_d;
   logic [CRED_W-1:0]   cred_q, cred_d;
   logic [NARROW_W-1:0] rdata_q, rdata_d;
   logic                rvalid_q, wcredit_q;

   ah_pktconv_fifo #(.W(WIDE_W), .DEPTH(DEPTH)) u_fifo (
      .clk_i   (clk_i),
      .rstn_i  (rstn_i),
      .push_i  (wvalid_i),
      .pop_i   (pop),
      .dat_i   (wdata_i),
      .dat_o   (head),
      .empty_o (empty)
   );

   for (genvar g = 0; g < LANES; g++) begin : g_slice
      assign slice[g] = head[g*NARROW_W +: NARROW_W];
   end

`ifdef AH_PKTCONV_W2N_MSB_FIRST_EN
   assign sel = LW'(LANES - 1) - lane_q;
`else
   assign sel = lane_q;
`endif

   // Only the registered credit count gates a beat; a same-cycle rcredit_i counts next cycle.
   assign beat = !empty && (cred_q != '0);
   assign last = (lane_q == LW'(LANES - 1));
   assign pop  = beat && last;

   always_comb begin
      cred_d  = cred_q;
      lane_d  = lane_q;
      rdata_d = rdata_q;
      if (rcredit_i && !beat && (cred_q != '1)) cred_d = cred_q + 1'b1;
      else if (beat && !rcredit_i)              cred_d = cred_q - 1'b1;
      if (beat) begin
         rdata_d = slice[sel];
         lane_d  = last ? '0 : lane_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         cred_q    <= '0;
         lane_q    <= '0;
         rdata_q   <= '0;
         rvalid_q  <= 1'b0;
         wcredit_q <= 1'b0;
      end else begin
         cred_q    <= cred_d;
         lane_q    <= lane_d;
         rdata_q   <= rdata_d;
         rvalid_q  <= beat;
         wcredit_q <= pop;
      end
   end

   assign rdata_o   = rdata_q;
   assign rvalid_o  = rvalid_q;
   assign wcredit_o = wcredit_q;
endmodule

// File: tb/tb_ah_packet_converter_w2n.sv
// Scoreboard bench for ah_packet_converter_w2n; expected lanes are queued by the stimulus and popped by a monitor.
module tb_ah_packet_converter_w2n;
   logic        clk_i = 1'b0;
   logic        rstn_i = 1'b0;
   logic [14:0] wdata_i = '0;
   logic        wvalid_i = 1'b0;
   logic        wcredit_o;
   logic [4:0]  rdata_o;
   logic        rvalid_o;
   logic        rcredit_i = 1'b0;

   typedef struct packed {
      logic [4:0] d;
      logic       wc;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   vectors = 0;
   int   miscompares = 0;
   int   rv_seen = 0;
   int   rv_run = 0;
   int   rv_maxrun = 0;
   int   ucred = 2;

   ah_packet_converter_w2n dut (
      .clk_i     (clk_i),
      .rstn_i    (rstn_i),
      .wdata_i   (wdata_i),
      .wvalid_i  (wvalid_i),
      .wcredit_o (wcredit_o),
      .rdata_o   (rdata_o),
      .rvalid_o  (rvalid_o),
      .rcredit_i (rcredit_i)
   );

   always #5 clk_i = ~clk_i;

   always @(negedge clk_i) begin
      if (rstn_i) begin
         if (rvalid_o) begin
            rv_seen++;
            rv_run++;
            if (rv_run > rv_maxrun) rv_maxrun = rv_run;
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL unexpected_lane: got rdata=%0h, required no beat", rdata_o);
            end else begin
               mon_e = exp_q.pop_front();
               if (rdata_o !== mon_e.d || wcredit_o !== mon_e.wc) begin
                  miscompares++;
                  $display("FAIL lane: got rdata=%0h wcredit=%0b, required rdata=%0h wcredit=%0b",
                           rdata_o, wcredit_o, mon_e.d, mon_e.wc);
               end
            end
         end else begin
            rv_run = 0;
            if (wcredit_o) begin
               vectors++;
               miscompares++;
               $display("FAIL stray_wcredit: got wcredit=1 without rvalid, required 0");
            end
         end
         if (wcredit_o) ucred++;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic timeout(input string name);
      vectors++;
      miscompares++;
      $display("FAIL %s: bound expired", name);
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      rstn_i = 1'b0;
      wvalid_i = 1'b0;
      rcredit_i = 1'b0;
      step();
      step();
      rstn_i = 1'b1;
      exp_q.delete();
      ucred = 2;
   endtask

   task automatic credits(input int n);
      repeat (n) begin
         rcredit_i = 1'b1;
         step();
      end
      rcredit_i = 1'b0;
   endtask

   task automatic write_word(input logic [14:0] w);
      int t = 0;
      while (ucred == 0 && t < 100) begin
         step();
         t++;
      end
      if (ucred == 0) timeout("write_wait");
      else begin
         wdata_i = w;
         wvalid_i = 1'b1;
         ucred--;
         step();
         wvalid_i = 1'b0;
      end
   endtask

   task automatic raw_write(input logic [14:0] w);
      wdata_i = w;
      wvalid_i = 1'b1;
      step();
      wvalid_i = 1'b0;
   endtask

   // Lanes given in LSB-first order; the MSB-first build emits them reversed.
   task automatic exp3(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
`ifdef AH_PKTCONV_W2N_MSB_FIRST_EN
      exp_q.push_back('{d: c, wc: 1'b0});
      exp_q.push_back('{d: b, wc: 1'b0});
      exp_q.push_back('{d: a, wc: 1'b1});
`else
      exp_q.push_back('{d: a, wc: 1'b0});
      exp_q.push_back('{d: b, wc: 1'b0});
      exp_q.push_back('{d: c, wc: 1'b1});
`endif
   endtask

   task automatic drain();
      int t = 0;
      while (exp_q.size() != 0 && t < 200) begin
         step();
         t++;
      end
      if (exp_q.size() != 0) begin
         timeout("drain");
         exp_q.delete();
      end
      step();
      step();
   endtask

   task automatic quiet(input int n, input string name);
      int s = rv_seen;
      repeat (n) step();
      check(name, rv_seen - s, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      do_reset();
      check("rst_rvalid", 32'(rvalid_o), 0);
      check("rst_rdata", 32'(rdata_o), 0);
      check("rst_wcredit", 32'(wcredit_o), 0);
      check("rst_cnt", 32'(dut.cred_q), 0);
      check("rst_lane", 32'(dut.lane_q), 0);
      check("rst_fifo_empty", 32'(dut.empty), 1);

      // Basic serialization and N+2 latency
      credits(3);
      exp3(5'h1C, 5'h15, 5'h1E);
      write_word(15'h7ABC);
      check("lat_n1", 32'(rvalid_o), 0);
      step();
      check("lat_n2", 32'(rvalid_o), 1);
      drain();
      check("basic_cnt", 32'(dut.cred_q), 0);

      // Credit stall mid-word
      credits(1);
      exp3(5'h1C, 5'h15, 5'h1E);
      write_word(15'h7ABC);
      step();
      step();
      quiet(10, "stall_quiet");
      check("stall_pending", exp_q.size(), 2);
      credits(2);
      drain();
      check("stall_cnt", 32'(dut.cred_q), 0);

      // FIFO full, dropped overflow write, back-to-back words
      write_word(15'h0001);
      write_word(15'h7FFF);
      raw_write(15'h5555);
      quiet(5, "full_quiet");
      exp3(5'h01, 5'h00, 5'h00);
      exp3(5'h1F, 5'h1F, 5'h1F);
      rv_maxrun = 0;
      credits(6);
      drain();
      check("full_run", rv_maxrun, 6);
      quiet(6, "drop_quiet");

      // Steady stream with rcredit coinciding with every beat
      credits(2);
      exp3(5'h1C, 5'h15, 5'h1E);
      exp3(5'h01, 5'h00, 5'h00);
      exp3(5'h1F, 5'h1F, 5'h1F);
      exp3(5'h01, 5'h19, 5'h10);
      rv_maxrun = 0;
      fork
         begin
            write_word(15'h7ABC);
            write_word(15'h0001);
            write_word(15'h7FFF);
            write_word(15'h4321);
         end
         begin
            step();
            credits(12);
         end
      join
      drain();
      check("stream_run", rv_maxrun, 12);
      check("stream_cnt", 32'(dut.cred_q), 2);

      // Credit counter saturation
      do_reset();
      credits(20);
      check("sat_cnt", 32'(dut.cred_q), 15);
      exp3(5'h01, 5'h19, 5'h10);
      exp3(5'h1F, 5'h1F, 5'h1F);
      exp3(5'h1C, 5'h15, 5'h1E);
      exp3(5'h01, 5'h00, 5'h00);
      exp3(5'h01, 5'h19, 5'h10);
      write_word(15'h4321);
      write_word(15'h7FFF);
      write_word(15'h7ABC);
      write_word(15'h0001);
      write_word(15'h4321);
      drain();
      check("sat_drained_cnt", 32'(dut.cred_q), 0);
      write_word(15'h7ABC);
      quiet(8, "sat_stall");
      exp3(5'h1C, 5'h15, 5'h1E);
      credits(3);
      drain();

      // Reset after lane 0 of a word
      credits(1);
`ifdef AH_PKTCONV_W2N_MSB_FIRST_EN
      exp_q.push_back('{d: 5'h1E, wc: 1'b0});
`else
      exp_q.push_back('{d: 5'h1C, wc: 1'b0});
`endif
      write_word(15'h7ABC);
      step();
      step();
      check("rst_mid_lane0_seen", exp_q.size(), 0);
      rstn_i = 1'b0;
      step();
      rstn_i = 1'b1;
      ucred = 2;
      check("rst_mid_rvalid", 32'(rvalid_o), 0);
      check("rst_mid_wcredit", 32'(wcredit_o), 0);
      check("rst_mid_fifo_empty", 32'(dut.empty), 1);
      check("rst_mid_lane", 32'(dut.lane_q), 0);
      credits(3);
      exp3(5'h01, 5'h19, 5'h10);
      write_word(15'h4321);
      drain();
      check("rst_mid_cnt", 32'(dut.cred_q), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
